// File: rtl/elevator_car_ctrl_pkg.sv
// Shared definitions for the elevator car controller:
// controller states, travel directions and the floor index width.
package elevator_car_ctrl_pkg;

   localparam int FLOOR_W = 3;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef logic [FLOOR_W-1:0] floor_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } car_state_t;

endpackage

// File: rtl/elevator_car_ctrl_cycle_timer.sv
// Load/enable counter running 0..MAX-1 with a terminal-count flag.
// Ports: clk, reset (async high), load (count<=0), enable (count up), tc (count==MAX-1).
module cycle_timer #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic enable,
   output logic tc
);

   localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

   logic [W-1:0] count;

   assign tc = (count == W'(MAX - 1));

   // Saturates at the terminal count; the owner decides what follows.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (enable && !tc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/elevator_car_ctrl.sv
// Single elevator car controller: latches floor calls, SCAN scheduling,
// floor-to-floor travel timing and door dwell timing.
// Ports: clk, reset (async high), call_valid/call_floor (call strobe),
// direction (1=up), current_floor, open, busy (not IDLE), pending (call mask).
module elevator_car_ctrl
   import elevator_car_ctrl_pkg::*;
#(
   parameter int NUM_FLOORS    = 6,
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  call_valid,
   input  logic [2:0]            call_floor,
   output logic                  direction,
   output logic [2:0]            current_floor,
   output logic                  open,
   output logic                  busy,
   output logic [NUM_FLOORS-1:0] pending
);

   typedef logic [NUM_FLOORS-1:0] mask_t;

   // One bit wider than a floor index so NUM_FLOORS=8 does not wrap.
   localparam logic [FLOOR_W:0] NF_LIM = (FLOOR_W + 1)'(NUM_FLOORS);

   function automatic mask_t floor_mask(input floor_t f);
      mask_t m;
      m = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         m[i] = (int'(f) == i);
      end
      return m;
   endfunction

   // Any call strictly above (up=1) or strictly below (up=0) floor f.
   function automatic logic calls_beyond(
      input mask_t  mask,
      input floor_t f,
      input logic   up
   );
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (up ? (i > int'(f)) : (i < int'(f))) begin
            hit = hit | mask[i];
         end
      end
      return hit;
   endfunction

   car_state_t state;

   floor_t next_floor;
   mask_t  here_mask;
   mask_t  next_mask;
   mask_t  set_mask;
   mask_t  clr_mask;
   logic   in_range;
   logic   restart;
   logic   here;
   logic   next_hit;
   logic   ahead;
   logic   behind;
   logic   ahead_next;
   logic   flip_dir;

   logic   travel_en;
   logic   travel_ld;
   logic   travel_tc;
   logic   door_en;
   logic   door_ld;
   logic   door_tc;

   assign next_floor = (direction == DIR_UP) ?
                       current_floor + 1'b1 :
                       current_floor - 1'b1;

   assign flip_dir = (direction == DIR_UP) ? DIR_DOWN : DIR_UP;

   assign in_range  = {1'b0, call_floor} < NF_LIM;
   assign here_mask = floor_mask(current_floor);
   assign next_mask = floor_mask(next_floor);

   // A call for the floor whose door is open only extends the dwell.
   assign restart = call_valid
                  & (state == DOOR)
                  & (call_floor == current_floor);

   assign set_mask = (call_valid && in_range && !restart) ?
                     floor_mask(call_floor) : '0;

   assign here       = |(pending & here_mask);
   assign next_hit   = |(pending & next_mask);
   assign ahead      = calls_beyond(pending, current_floor, direction);
   assign behind     = calls_beyond(pending, current_floor, flip_dir);
   assign ahead_next = calls_beyond(pending, next_floor, direction);

   // Served floor is cleared; a same-edge call is OR-ed back afterwards.
   always_comb begin
      clr_mask = '0;
      if (state == IDLE && here) begin
         clr_mask = here_mask;
      end else if (state == MOVE && travel_tc && next_hit) begin
         clr_mask = next_mask;
      end
   end

   // Timers sit at zero outside their own state, so entry starts at 0.
   assign travel_en = (state == MOVE);
   assign travel_ld = !travel_en || travel_tc;
   assign door_en   = (state == DOOR);
   assign door_ld   = !door_en || restart || door_tc;

   cycle_timer #(
      .MAX (TRAVEL_CYCLES)
   ) u_travel (
      .clk    (clk),
      .reset  (reset),
      .load   (travel_ld),
      .enable (travel_en),
      .tc     (travel_tc)
   );

   cycle_timer #(
      .MAX (DOOR_CYCLES)
   ) u_door (
      .clk    (clk),
      .reset  (reset),
      .load   (door_ld),
      .enable (door_en),
      .tc     (door_tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         current_floor <= '0;
         direction     <= DIR_UP;
         open          <= 1'b0;
         busy          <= 1'b0;
         pending       <= '0;
      end else begin
         pending <= (pending & ~clr_mask) | set_mask;
         unique case (state)
            IDLE: begin
               if (here) begin
                  state <= DOOR;
                  open  <= 1'b1;
                  busy  <= 1'b1;
               end else if (ahead) begin
                  state <= MOVE;
                  busy  <= 1'b1;
               end else if (behind) begin
                  state     <= MOVE;
                  busy      <= 1'b1;
                  direction <= flip_dir;
               end
            end
            MOVE: begin
               if (travel_tc) begin
                  current_floor <= next_floor;
                  if (next_hit) begin
                     state <= DOOR;
                     open  <= 1'b1;
                  end else if (!ahead_next) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            DOOR: begin
               if (!restart && door_tc) begin
                  state <= IDLE;
                  open  <= 1'b0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               open  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // MOVE is only entered or kept with a call beyond, so the car stays in range.
   a_floor_range : assert property (
      @(posedge clk) disable iff (reset)
      {1'b0, current_floor} < NF_LIM
   );

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Self-checking bench for elevator_car_ctrl: cycle-by-cycle comparison
// against a behavioural car model plus directed scenario checks.
module tb_elevator_car_ctrl;

   localparam int NF = 6;
   localparam int TC = 4;
   localparam int DC = 6;

   localparam int P_IDLE = 0;
   localparam int P_MOVE = 1;
   localparam int P_DOOR = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          call_valid = 1'b0;
   logic [2:0]    call_floor = 3'd0;
   logic          direction;
   logic [2:0]    current_floor;
   logic          open;
   logic          busy;
   logic [NF-1:0] pending;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   elevator_car_ctrl #(
      .NUM_FLOORS    (NF),
      .TRAVEL_CYCLES (TC),
      .DOOR_CYCLES   (DC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .call_valid    (call_valid),
      .call_floor    (call_floor),
      .direction     (direction),
      .current_floor (current_floor),
      .open          (open),
      .busy          (busy),
      .pending       (pending)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
      end
   endtask

   // Behavioural model: countdowns to the next event, a call list,
   // and the SCAN rule evaluated by scanning the list.
   int m_floor;
   bit m_up;
   int m_phase;
   int m_travel;
   int m_door;
   bit m_open;
   bit m_calls [NF];

   function automatic bit any_beyond(input int f, input bit up);
      for (int i = 0; i < NF; i++)
         if (m_calls[i] && (up ? (i > f) : (i < f))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [NF-1:0] model_mask();
      logic [NF-1:0] m;
      for (int i = 0; i < NF; i++) m[i] = m_calls[i];
      return m;
   endfunction

   task automatic model_reset();
      m_floor = 0;
      m_up = 1'b1;
      m_phase = P_IDLE;
      m_travel = 0;
      m_door = 0;
      m_open = 1'b0;
      for (int i = 0; i < NF; i++) m_calls[i] = 1'b0;
   endtask

   task automatic model_step(input bit cv, input int cf);
      bit restart;
      int served;
      int nf;
      served = -1;
      restart = cv && (m_phase == P_DOOR) && (cf == m_floor);
      case (m_phase)
         P_IDLE: begin
            if (m_calls[m_floor]) begin
               m_phase = P_DOOR;
               m_open = 1'b1;
               m_door = DC;
               served = m_floor;
            end else if (any_beyond(m_floor, m_up)) begin
               m_phase = P_MOVE;
               m_travel = TC;
            end else if (any_beyond(m_floor, !m_up)) begin
               m_up = !m_up;
               m_phase = P_MOVE;
               m_travel = TC;
            end
         end
         P_MOVE: begin
            m_travel--;
            if (m_travel == 0) begin
               nf = m_up ? m_floor + 1 : m_floor - 1;
               if (m_calls[nf]) begin
                  m_phase = P_DOOR;
                  m_open = 1'b1;
                  m_door = DC;
                  served = nf;
               end else if (any_beyond(nf, m_up)) begin
                  m_travel = TC;
               end else begin
                  m_phase = P_IDLE;
               end
               m_floor = nf;
            end
         end
         P_DOOR: begin
            if (restart) begin
               m_door = DC;
            end else begin
               m_door--;
               if (m_door == 0) begin
                  m_open = 1'b0;
                  m_phase = P_IDLE;
               end
            end
         end
         default: ;
      endcase
      if (served >= 0) m_calls[served] = 1'b0;
      if (cv && cf < NF && !restart) m_calls[cf] = 1'b1;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_reset();
         else model_step(call_valid, int'(call_floor));
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("m_floor", current_floor, m_floor);
         chk("m_dir", direction, m_up);
         chk("m_open", open, m_open);
         chk("m_busy", busy, m_phase != P_IDLE);
         chk("m_pending", pending, model_mask());
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic call(input int f);
      call_valid = 1'b1;
      call_floor = 3'(f);
      @(negedge clk);
      call_valid = 1'b0;
   endtask

   task automatic wait_open(input string name, input bit want,
                            input int bound);
      int n;
      n = 0;
      while (open !== want && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(name, open, want);
   endtask

   task automatic count_open(output int n);
      n = 0;
      while (open === 1'b1 && n < 20) begin
         n++;
         step(1);
      end
   endtask

   int n;

   initial begin
      step(2);
      reset = 1'b0;
      step(1);
      chk("rst_floor", current_floor, 0);
      chk("rst_dir", direction, 1);
      chk("rst_open", open, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pending", pending, 0);

      // Call at the current floor.
      call(0);
      chk("c0_pend", pending, 6'b000001);
      chk("c0_closed", open, 0);
      step(1);
      chk("c0_open", open, 1);
      chk("c0_clr", pending, 0);
      count_open(n);
      chk("c0_dwell", n, DC);
      chk("c0_idle", busy, 0);

      // Travel 0 -> 3.
      call(3);
      chk("c3_pend", pending, 6'b001000);
      step(1);
      chk("c3_busy", busy, 1);
      chk("c3_dir", direction, 1);
      step(3);
      chk("c3_f0", current_floor, 0);
      step(1);
      chk("c3_f1", current_floor, 1);
      step(4);
      chk("c3_f2", current_floor, 2);
      step(4);
      chk("c3_f3", current_floor, 3);
      chk("c3_open", open, 1);
      chk("c3_clr", pending, 0);
      wait_open("c3_close", 1'b0, 10);

      // Up past 3 toward 5, with a call for 1 arriving en route.
      call(5);
      step(1);
      call(1);
      wait_open("up5_open", 1'b1, 20);
      chk("up5_floor", current_floor, 5);
      chk("up5_first", pending, 6'b000010);
      chk("up5_dir", direction, 1);
      wait_open("up5_close", 1'b0, 10);
      wait_open("dn1_open", 1'b1, 40);
      chk("dn1_floor", current_floor, 1);
      chk("dn1_dir", direction, 0);

      // Re-call of the open floor restarts the dwell.
      step(2);
      call(1);
      chk("rs_pend", pending, 0);
      chk("rs_open", open, 1);
      count_open(n);
      chk("rs_dwell", n, DC);
      chk("rs_idle", busy, 0);

      // Out-of-range floors.
      call(7);
      chk("oor7_pend", pending, 0);
      step(1);
      chk("oor7_busy", busy, 0);
      call(6);
      chk("oor6_pend", pending, 0);
      step(1);
      chk("oor6_busy", busy, 0);

      // Asynchronous reset while moving.
      call(4);
      step(6);
      chk("prerst_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_floor", current_floor, 0);
      chk("arst_dir", direction, 1);
      chk("arst_open", open, 0);
      chk("arst_pend", pending, 0);
      chk("arst_busy", busy, 0);
      @(negedge clk);
      step(1);
      reset = 1'b0;
      step(1);

      // Calls on every floor above 0: one upward sweep.
      for (int k = 1; k < NF; k++) call(k);
      for (int k = 1; k < NF; k++) begin
         wait_open("sw_open", 1'b1, 30);
         chk("sw_floor", current_floor, k);
         chk("sw_dir", direction, 1);
         wait_open("sw_close", 1'b0, 10);
      end
      chk("sw_idle", busy, 0);
      chk("sw_pend", pending, 0);
      step(3);
      chk("sw_stay", current_floor, NF - 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
